// File: rtl/bsat_pkg.sv
// Shared types and sizing helpers for the bit-serial adder tree.
// Provides the FSM state enum, the per-stage tag bundle and the LEVELS/RES_BITS formulas.
package bsat_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        EXTEND = 2'd2
    } bsat_state_e;

    // Tag bundle that travels alongside every serial bit through the tree
    typedef struct packed {
        logic v;   // bit present
        logic f;   // bit 0 of the frame
        logic l;   // last bit of the frame
    } stage_tag_t;

    localparam stage_tag_t TAG_NONE = '0;

    // Number of tree levels: ceil(log2(n))
    function automatic int levels(input int n);
        int l;
        l = 0;
        while ((1 << l) < n) begin
            l = l + 1;
        end
        return l;
    endfunction

    // Full-precision width of the sum of n operands of w bits each
    function automatic int res_bits(input int w, input int n);
        return w + levels(n);
    endfunction

endpackage

// File: rtl/bit_serial_adder_tree_p_node.sv
// serial_add_node: one 2-input LSB-first serial adder stage.
// Ports: clk, reset (async, active-high), clean (sync flush), a/b operand bits,
// tag_in (v/f/l of the incoming bit), sum (registered sum bit), tag_out (registered tags).
module serial_add_node
    import bsat_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clean,
    input  logic       a,
    input  logic       b,
    input  stage_tag_t tag_in,
    output logic       sum,
    output stage_tag_t tag_out
);

    logic carry_q;
    logic cin;
    logic sum_d;
    logic carry_d;

    // The first bit of a frame never sees the previous frame's carry
    always_comb begin
        cin     = tag_in.f ? 1'b0 : carry_q;
        sum_d   = a ^ b ^ cin;
        carry_d = (a & b) | (a & cin) | (b & cin);
    end

    // Bubbles (v=0) keep the carry so a stalled frame resumes intact;
    // sum and tags are cleared so nothing downstream looks valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            sum     <= 1'b0;
            tag_out <= TAG_NONE;
        end else if (clean) begin
            carry_q <= 1'b0;
            sum     <= 1'b0;
            tag_out <= TAG_NONE;
        end else if (tag_in.v) begin
            carry_q <= carry_d;
            sum     <= sum_d;
            tag_out <= tag_in;
        end else begin
            sum     <= 1'b0;
            tag_out <= TAG_NONE;
        end
    end

endmodule

// File: rtl/bit_serial_adder_tree_p.sv
// bit_serial_adder_tree_p: sums NUM_INPUTS serial LSB-first operands of OPERAND_BITS
// each into a RES_BITS-wide serial result, padding frames with zero/sign extension.
// Ports: clk, reset (async, active-high), clean (sync flush), in_valid/in_first/in_bits
// beat input with in_ready handshake; out_bit/out_valid/out_first/out_last serial sum;
// frame_err sticky protocol-error flag.
// Optional macro BSAT_PARALLEL_OUT_EN adds out_word/out_word_valid (deserialised sum).
module bit_serial_adder_tree_p
    import bsat_pkg::*;
#(
    parameter int NUM_INPUTS   = 8,
    parameter int OPERAND_BITS = 8,
    parameter bit SIGNED       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clean,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic [NUM_INPUTS-1:0] in_bits,
    output logic                  in_ready,
    output logic                  out_bit,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  frame_err
`ifdef BSAT_PARALLEL_OUT_EN
    ,
    output logic [res_bits(OPERAND_BITS, NUM_INPUTS)-1:0] out_word,
    output logic                                          out_word_valid
`endif
);

    localparam int LEVELS   = levels(NUM_INPUTS);
    localparam int RES_BITS = res_bits(OPERAND_BITS, NUM_INPUTS);
    localparam int NODES    = NUM_INPUTS - 1;
    localparam int CNT_W    = $clog2(OPERAND_BITS + 1);
    localparam int EXT_W    = $clog2(LEVELS + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OPERAND_BITS - 1);
    localparam logic [EXT_W-1:0] LAST_EXT = EXT_W'(LEVELS - 1);

    bsat_state_e           state_q;
    bsat_state_e           state_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [EXT_W-1:0]      ext_cnt_q;
    logic [NUM_INPUTS-1:0] msb_hold_q;

    logic                  accept;
    logic                  last_bit;
    logic                  last_ext;
    logic                  err_set;
    logic [NUM_INPUTS-1:0] leaf_bits;
    stage_tag_t            leaf_tag;

    logic [NODES-1:0]      node_sum;
    stage_tag_t            node_tag [NODES];

    // clean takes priority over any beat offered in the same cycle
    assign accept   = in_valid & in_ready & ~clean;
    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign last_ext = (ext_cnt_q == LAST_EXT);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (clean) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (accept && in_first) begin
                    state_d = STREAM;
                end
            end
            (state_q == STREAM): begin
                if (accept && last_bit) begin
                    state_d = EXTEND;
                end
            end
            (state_q == EXTEND): begin
                if (last_ext) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output / leaf-beat logic ----------------
    always_comb begin
        in_ready  = 1'b1;
        leaf_bits = in_bits;
        leaf_tag  = TAG_NONE;
        err_set   = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                leaf_tag.v = accept & in_first;
                leaf_tag.f = accept & in_first;
                err_set    = accept & ~in_first;
            end
            (state_q == STREAM): begin
                leaf_tag.v = accept;
                err_set    = accept & in_first;
            end
            (state_q == EXTEND): begin
                // One padding beat per level keeps every carry in range
                in_ready   = 1'b0;
                leaf_tag.v = 1'b1;
                leaf_tag.l = last_ext;
                leaf_bits  = SIGNED ? msb_hold_q : '0;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ---------------- frame counters and error flag ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            ext_cnt_q  <= '0;
            msb_hold_q <= '0;
            frame_err  <= 1'b0;
        end else if (clean) begin
            bit_cnt_q  <= '0;
            ext_cnt_q  <= '0;
            msb_hold_q <= '0;
            frame_err  <= 1'b0;
        end else begin
            if (err_set) begin
                frame_err <= 1'b1;
            end
            unique case (1'b1)
                (state_q == IDLE): begin
                    ext_cnt_q <= '0;
                    if (accept && in_first) begin
                        bit_cnt_q <= CNT_W'(1);
                    end
                end
                (state_q == STREAM): begin
                    if (accept) begin
                        if (last_bit) begin
                            bit_cnt_q  <= '0;
                            msb_hold_q <= in_bits;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                (state_q == EXTEND): begin
                    ext_cnt_q <= last_ext ? '0 : ext_cnt_q + EXT_W'(1);
                end
                default: begin
                    bit_cnt_q <= '0;
                    ext_cnt_q <= '0;
                end
            endcase
        end
    end

    // ---------------- adder tree ----------------
    // Nodes are stored level by level: level k starts at NUM_INPUTS - (NUM_INPUTS >> k).
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int CNT = NUM_INPUTS >> (k + 1);
        localparam int OFS = NUM_INPUTS - (NUM_INPUTS >> k);

        for (genvar j = 0; j < CNT; j++) begin : g_node
            logic       a_bit;
            logic       b_bit;
            stage_tag_t t_in;

            if (k == 0) begin : g_leaf
                assign a_bit = leaf_bits[2*j];
                assign b_bit = leaf_bits[2*j+1];
                assign t_in  = leaf_tag;
            end else begin : g_inner
                localparam int PREV = NUM_INPUTS - (NUM_INPUTS >> (k - 1));
                assign a_bit = node_sum[PREV+2*j];
                assign b_bit = node_sum[PREV+2*j+1];
                // Sibling tags are identical; AND keeps both paths live
                assign t_in  = node_tag[PREV+2*j] & node_tag[PREV+2*j+1];
            end

            serial_add_node u_node (
                .clk     (clk),
                .reset   (reset),
                .clean   (clean),
                .a       (a_bit),
                .b       (b_bit),
                .tag_in  (t_in),
                .sum     (node_sum[OFS+j]),
                .tag_out (node_tag[OFS+j])
            );
        end
    end

    assign out_bit   = node_sum[NODES-1];
    assign out_valid = node_tag[NODES-1].v;
    assign out_first = node_tag[NODES-1].f;
    assign out_last  = node_tag[NODES-1].l;

`ifdef BSAT_PARALLEL_OUT_EN
    // Upper RES_BITS-1 bits of the word being assembled; the current
    // root bit completes it on the out_last beat.
    logic [RES_BITS-2:0] shift_q;
    logic [RES_BITS-1:0] shift_d;

    assign shift_d = {out_bit, shift_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q        <= '0;
            out_word       <= '0;
            out_word_valid <= 1'b0;
        end else if (clean) begin
            shift_q        <= '0;
            out_word       <= '0;
            out_word_valid <= 1'b0;
        end else begin
            out_word_valid <= 1'b0;
            if (out_valid) begin
                shift_q <= shift_d[RES_BITS-1:1];
                if (out_last) begin
                    out_word       <= shift_d;
                    out_word_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bit_serial_adder_tree_p.sv
// Directed bench for bit_serial_adder_tree_p: N=8, W=4, one unsigned and one
// signed instance driven by the same beats, results collected from the roots.
module tb_bit_serial_adder_tree_p;

    logic       clk = 1'b0;
    logic       reset;
    logic       clean;
    logic       in_valid;
    logic       in_first;
    logic [7:0] in_bits;

    logic ir0, ob0, ov0, of0, ol0, fe0;
    logic ir1, ob1, ov1, of1, ol1, fe1;

`ifdef BSAT_PARALLEL_OUT_EN
    logic [6:0] ow0, ow1;
    logic       owv0, owv1;
`endif

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int c0   = 0;

    typedef struct {
        logic [6:0] w;
        int         n;
        int         fc;
        int         span;
    } res_t;

    res_t q0[$];
    res_t q1[$];

    logic [6:0] w0, w1;
    int n0 = 0, n1 = 0, f0 = 0, f1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serial_adder_tree_p #(
        .NUM_INPUTS(8), .OPERAND_BITS(4), .SIGNED(1'b0)
    ) u_uns (
        .clk(clk), .reset(reset), .clean(clean),
        .in_valid(in_valid), .in_first(in_first), .in_bits(in_bits),
        .in_ready(ir0), .out_bit(ob0), .out_valid(ov0),
        .out_first(of0), .out_last(ol0), .frame_err(fe0)
`ifdef BSAT_PARALLEL_OUT_EN
        , .out_word(ow0), .out_word_valid(owv0)
`endif
    );

    bit_serial_adder_tree_p #(
        .NUM_INPUTS(8), .OPERAND_BITS(4), .SIGNED(1'b1)
    ) u_sgn (
        .clk(clk), .reset(reset), .clean(clean),
        .in_valid(in_valid), .in_first(in_first), .in_bits(in_bits),
        .in_ready(ir1), .out_bit(ob1), .out_valid(ov1),
        .out_first(of1), .out_last(ol1), .frame_err(fe1)
`ifdef BSAT_PARALLEL_OUT_EN
        , .out_word(ow1), .out_word_valid(owv1)
`endif
    );

    // Root collectors
    always @(negedge clk) begin
        res_t r;
        if (ov0) begin
            if (of0) begin w0 = '0; n0 = 0; f0 = cyc; end
            if (n0 < 7) w0[n0[2:0]] = ob0;
            n0++;
            if (ol0) begin
                r.w = w0; r.n = n0; r.fc = f0; r.span = cyc - f0;
                q0.push_back(r);
            end
        end
        if (ov1) begin
            if (of1) begin w1 = '0; n1 = 0; f1 = cyc; end
            if (n1 < 7) w1[n1[2:0]] = ob1;
            n1++;
            if (ol1) begin
                r.w = w1; r.n = n1; r.fc = f1; r.span = cyc - f1;
                q1.push_back(r);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ops: operand n in ops[4n+3:4n]
    task automatic send_frame(input logic [31:0] ops, input int stall_at,
                              input int nstall, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < nstall; s++) begin
                    in_valid = 1'b0;
                    step();
                    chk("stall_ready", {31'd0, ir0}, 32'd1);
                end
            end
            in_valid = 1'b1;
            in_first = (k == 0);
            for (int n = 0; n < 8; n++) in_bits[n] = ops[4*n+k];
            if (k == 0) c0 = cyc;
            step();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_bits  = '0;
    endtask

    task automatic ext_wait(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_ext_ready"}, {31'd0, ir0}, 32'd0);
            step();
        end
        chk({tag, "_idle_ready"}, {31'd0, ir0}, 32'd1);
    endtask

    task automatic get_result(input string tag, input logic [6:0] eu, input logic [6:0] es,
                              input int espan, input bit lat);
        int   t;
        logic got;
        res_t r0, r1;
        t = 0;
        while ((q0.size() == 0 || q1.size() == 0) && t < 40) begin
            step();
            t++;
        end
        got = (q0.size() > 0) && (q1.size() > 0);
        chk({tag, "_arrive"}, {31'd0, got}, 32'd1);
        if (got) begin
            r0 = q0.pop_front();
            r1 = q1.pop_front();
            chk({tag, "_uns"}, {25'd0, r0.w}, {25'd0, eu});
            chk({tag, "_sgn"}, {25'd0, r1.w}, {25'd0, es});
            chk({tag, "_len"}, r0.n + r1.n, 32'd14);
            chk({tag, "_span"}, r0.span, espan);
            if (lat) chk({tag, "_lat"}, r0.fc - c0, 32'd3);
        end
    endtask

    initial begin
        reset = 1'b1; clean = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_bits = '0;
        #1;
        chk("rst_outs0", {27'd0, ov0, of0, ol0, ob0, fe0}, 32'd0);
        chk("rst_outs1", {27'd0, ov1, of1, ol1, ob1, fe1}, 32'd0);
        chk("rst_ready", {30'd0, ir0, ir1}, 32'd3);
        step(); step();
        reset = 1'b0;
        step();

        // All operands 15 (unsigned 120, signed -8 = 7'b1111000)
        send_frame(32'hFFFF_FFFF, -1, 0, 4);
        ext_wait("t1");
        get_result("t1", 7'd120, 7'd120, 6, 1'b1);

        // {7,-8,3,-1,5,2,-4,6}: unsigned 58, signed 10
        send_frame(32'h6C25_F387, -1, 0, 4);
        ext_wait("t2");
        get_result("t2", 7'd58, 7'd10, 6, 1'b1);

        // {1..8} with 3 bubbles before bit 2: unsigned 36, signed 20
        send_frame(32'h8765_4321, 2, 3, 4);
        ext_wait("t3");
        get_result("t3", 7'd36, 7'd20, 9, 1'b0);

        // Back-to-back: all 15 then all 0
        send_frame(32'hFFFF_FFFF, -1, 0, 4);
        ext_wait("b2b_a");
        send_frame(32'h0000_0000, -1, 0, 4);
        ext_wait("b2b_b");
        get_result("b2b_a", 7'd120, 7'd120, 6, 1'b0);
        get_result("b2b_b", 7'd0, 7'd0, 6, 1'b0);

        // Async reset mid-frame, then {1..8}
        send_frame(32'h6C25_F387, -1, 0, 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs0", {27'd0, ov0, of0, ol0, ob0, fe0}, 32'd0);
        chk("mid_rst_outs1", {27'd0, ov1, of1, ol1, ob1, fe1}, 32'd0);
        chk("mid_rst_ready", {31'd0, ir0}, 32'd1);
        step();
        reset = 1'b0;
        step();
        send_frame(32'h8765_4321, -1, 0, 4);
        ext_wait("t_rst");
        get_result("t_rst", 7'd36, 7'd20, 6, 1'b0);

        // clean mid-frame with a beat offered in the same cycle, then all-ones
        send_frame(32'hFFFF_FFFF, -1, 0, 2);
        clean = 1'b1; in_valid = 1'b1; in_first = 1'b0; in_bits = 8'hFF;
        step();
        clean = 1'b0; in_valid = 1'b0; in_bits = '0;
        chk("clean_outs", {29'd0, ov0, fe0, ov1}, 32'd0);
        chk("clean_ready", {31'd0, ir0}, 32'd1);
        send_frame(32'h1111_1111, -1, 0, 4);
        ext_wait("t_cln");
        get_result("t_cln", 7'd8, 7'd8, 6, 1'b0);

        // Bit 0 without in_first while idle
        in_valid = 1'b1; in_first = 1'b0; in_bits = 8'hFF;
        step();
        in_valid = 1'b0; in_bits = '0;
        chk("err_set", {30'd0, fe0, fe1}, 32'd3);
        chk("err_ready", {31'd0, ir0}, 32'd1);
        repeat (6) step();
        chk("err_nodata", q0.size() + q1.size(), 32'd0);
        chk("err_sticky", {31'd0, fe0}, 32'd1);
        clean = 1'b1;
        step();
        clean = 1'b0;
        chk("err_clear", {30'd0, fe0, fe1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder_tree_p.md
Name: bit_serial_adder_tree_p

Overview:
Parametrised bit-serial reduction tree. Sums NUM_INPUTS operands, each OPERAND_BITS wide, streamed LSB-first one bit per accepted beat. The block pads each frame with sign or zero extension itself, so the root emits a full-precision serial sum. It sits after the PE bit-serial multipliers and before the accumulator/deserializer, and generalises the fixed 8-input tree with frame tags, handshake and signed mode.

Parameters:
NUM_INPUTS, 8, operand count; power of 2, at least 2.
OPERAND_BITS, 8, bits per input operand; at least 2.
SIGNED, 0, 1 = two's-complement operands (MSB-hold extension); 0 = zero extension.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
clean  input  1  synchronous flush; same effect as reset, one cycle
in_valid  input  1  beat present on in_bits
in_first  input  1  beat is bit 0 (LSB) of a new frame
in_bits  input  NUM_INPUTS  one bit per operand, bit index n = operand n
in_ready  output  1  block accepts a beat this cycle
out_bit  output  1  serial sum bit
out_valid  output  1  out_bit is valid
out_first  output  1  out_bit is result LSB
out_last  output  1  out_bit is result MSB
frame_err  output  1  sticky; set on protocol violation, cleared by reset or clean

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- LEVELS = log2(NUM_INPUTS); RES_BITS = OPERAND_BITS + LEVELS. Each frame emits RES_BITS output bits.
- FSM states: IDLE, STREAM, EXTEND. Beat accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and STREAM; 0 in EXTEND.
- IDLE:
  - Accepted beat with in_first=1 becomes bit 0; bit_cnt <= 1; go to STREAM.
  - Accepted beat with in_first=0 is dropped and sets frame_err.
- STREAM:
  - Each accepted beat is the next bit; bit_cnt increments.
  - in_valid low stalls the frame and inserts a bubble; carries hold.
  - in_first=1 mid-frame sets frame_err; the bit is still used as data.
  - Accepting bit OPERAND_BITS-1 latches in_bits as msb_hold and moves to EXTEND.
- EXTEND:
  - Runs exactly LEVELS cycles, each injecting one leaf beat: msb_hold if SIGNED=1, else all zeros.
  - Then returns to IDLE. The next frame may start the following cycle, with no extra gap.
- Tree: LEVELS registered levels of 2-input serial nodes. Level 0 consumes leaf beats.
- Each node stage holds sum, carry, and tags v/f/l. When input v=1:
  - sum = a^b^cin, where cin = 0 if f=1, else the stored carry.
  - carry <= maj(a,b,cin).
  - Tags are copied forward.
- When input v=0, the stage carry holds and output v <= 0.
- Latency: a leaf beat at cycle t appears at the root at cycle t+LEVELS. The pipeline is free-running and drains regardless of in_valid.
- Leaf tags: f = bit 0; l = the last EXTEND beat.
- out_* are driven directly from the root stage. out_valid/out_first/out_last are never high without a valid bit.
- Result: out_bit stream = sum of operands mod 2^RES_BITS. The sum is exact, with no overflow possible.
- Reset or clean mid-frame: FSM -> IDLE, bit_cnt = 0, all carries and tags = 0, frame_err = 0.
- Output values after reset: out_bit, out_valid, out_first, out_last, frame_err = 0; in_ready = 1.
- clean and a beat in the same cycle: clean wins and the beat is dropped.

Optional Feature:
Macro BSAT_PARALLEL_OUT_EN.
- Defined: adds output ports out_word [RES_BITS-1:0] and out_word_valid [1].
- A shift register deserialises the root stream (LSB-first).
- out_word_valid pulses 1 cycle after out_last, with out_word holding the full sum.
- out_word holds its value until the next word; it is cleared to 0 by reset or clean.
- Undefined: these ports and this logic are absent; serial output only.

Decomposition:
- Package bsat_pkg:
  - state enum (IDLE/STREAM/EXTEND);
  - constant function for LEVELS;
  - the RES_BITS formula;
  - a stage tag struct {v,f,l}.
- Sub-module serial_add_node: one 2-input serial adder with carry register, f-gated carry-in and tag pipeline.
- The tree is built with generate loops over levels; node count per level halves.

Test Plan:
- N=8, W=4, SIGNED=0, all operands 15, contiguous beats -> root bits (LSB first) 0,0,0,1,1,1,1 (=120); out_first on bit 0, out_last on bit 6, latency 3.
- N=8, W=4, SIGNED=1, all operands -1 -> 7-bit result 1111000 (-8); operands {7,-8,...} mixed -> exact signed sum checked against a model.
- Stall: in_valid low for 3 cycles between bits 1 and 2 -> same result as contiguous; out_valid shows bubbles; in_ready low only during EXTEND.
- Back-to-back frames, in_first asserted the cycle after EXTEND ends -> both sums correct, no carry leakage between frames.
- Reset asserted mid-frame, then a new frame -> all outputs 0 during reset; the new frame sums correctly. Repeat using clean.
- Bit 0 sent without in_first in IDLE -> beat dropped, frame_err=1; clean -> frame_err=0.
